alu_share_arb: RTL and testbench

Two-requester round-robin scheduler that shares one combinational 16-bit `alu` (2-bit `op`, operands `i0`/`i1`, result `o`, carry `cout`) between two independent clients. Each client issues a request with valid/ready, the block latches it, drives the shared ALU for one cycle, and captures `o`/`cout`. It then returns the result to the issuing client with valid/ready. The block sits between client engines and the single ALU instance at the same hierarchy level, so the ALU itself stays untouched.

---
 rtl/alu_share_arb_pkg.sv | 26 ++
 rtl/alu_share_arb.sv | 148 ++++++++++++++
 tb/tb_alu_share_arb.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_share_arb_pkg.sv
// Shared definitions for the two-client ALU sharing scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Holds the scheduler FSM encoding, the default datapath width and the ALU
// opcode constants that clients and benches use when building requests.
package alu_share_arb_pkg;

  // Must match the width of the shared ALU instance.
  localparam int WIDTH_DEF = 16;

  // Scheduler FSM: one transaction in flight at a time.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // ALU opcodes. The scheduler passes these through untouched; their meaning
  // belongs to the ALU.
  localparam logic [1:0] OP_0 = 2'b00;
  localparam logic [1:0] OP_1 = 2'b01;
  localparam logic [1:0] OP_2 = 2'b10;
  localparam logic [1:0] OP_3 = 2'b11;

endpackage

// File: rtl/alu_share_arb.sv
// Round-robin scheduler sharing one combinational ALU between two clients.
// Latency: request accepted at edge N, ALU driven in N+1, response valid from N+2.
// Backpressure: rX_ready only in IDLE; response held stable until pX_ready.
//
// Ports:
//   clk, reset               clock, async active-high reset
//   r0_* / r1_*              request channels (valid/ready, op, a, b)
//   p0_* / p1_*, p_data, p_cout  response channels sharing one data bus
//   alu_op, alu_i0, alu_i1   drive the shared ALU
//   alu_o, alu_cout          ALU result, captured at the end of EXEC
//   busy                     high whenever a transaction is in flight
module alu_share_arb
  import alu_share_arb_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,

  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [1:0]       r0_op,
  input  logic [WIDTH-1:0] r0_a,
  input  logic [WIDTH-1:0] r0_b,

  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [1:0]       r1_op,
  input  logic [WIDTH-1:0] r1_a,
  input  logic [WIDTH-1:0] r1_b,

  output logic             p0_valid,
  input  logic             p0_ready,
  output logic             p1_valid,
  input  logic             p1_ready,
  output logic [WIDTH-1:0] p_data,
  output logic             p_cout,

  output logic [1:0]       alu_op,
  output logic [WIDTH-1:0] alu_i0,
  output logic [WIDTH-1:0] alu_i1,
  input  logic [WIDTH-1:0] alu_o,
  input  logic             alu_cout,

  output logic             busy
);

  state_t           state_q, state_d;
  logic             ptr_q;     // client favoured when both request
  logic             gnt_id_q;  // owner of the in-flight transaction
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] p_data_q;
  logic             p_cout_q;

  logic             accept;    // a request is taken this cycle
  logic             gnt1;      // the taken request belongs to client 1
  logic             resp_hs;   // response handshake this cycle

  // Next state, grant and response qualifiers.
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    gnt1     = 1'b0;
    resp_hs  = 1'b0;
    r0_ready = 1'b0;
    r1_ready = 1'b0;
    p0_valid = 1'b0;
    p1_valid = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (r0_valid || r1_valid) begin
          // Client 1 wins when it is alone, or when both ask and it is favoured.
          gnt1     = r1_valid && (!r0_valid || ptr_q);
          r0_ready = !gnt1;
          r1_ready = gnt1;
          accept   = 1'b1;
          state_d  = ST_EXEC;
        end
      end

      ST_EXEC: begin
        state_d = ST_RESP;
      end

      ST_RESP: begin
        p0_valid = !gnt_id_q;
        p1_valid = gnt_id_q;
        // Only the owner's ready counts; the other client's ready is ignored.
        if (gnt_id_q ? p1_ready : p0_ready) begin
          resp_hs = 1'b1;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, operand and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      ptr_q    <= 1'b0;
      gnt_id_q <= 1'b0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      p_data_q <= '0;
      p_cout_q <= 1'b0;
    end else begin
      state_q <= state_d;

      if (accept) begin
        gnt_id_q <= gnt1;
        op_q     <= gnt1 ? r1_op : r0_op;
        a_q      <= gnt1 ? r1_a  : r0_a;
        b_q      <= gnt1 ? r1_b  : r0_b;
      end

      // The ALU is combinational, so its outputs are valid by the end of EXEC.
      if (state_q == ST_EXEC) begin
        p_data_q <= alu_o;
        p_cout_q <= alu_cout;
      end

      // Fairness pointer moves only once the response has been taken.
      if (resp_hs) begin
        ptr_q <= !gnt_id_q;
      end
    end
  end

  // Operand registers drive the ALU directly; outside EXEC the ALU result is
  // simply not captured.
  assign alu_op = op_q;
  assign alu_i0 = a_q;
  assign alu_i1 = b_q;

  assign p_data = p_data_q;
  assign p_cout = p_cout_q;
  assign busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_share_arb.sv
// Self-checking bench for alu_share_arb with a transaction-level reference.
// Latency: n/a.
// Backpressure: randomised response ready and request valid.
module tb_alu_share_arb;
  import alu_share_arb_pkg::*;

  localparam int W = 16;
  localparam int N_SAT = 40;

  logic         clk = 1'b0;
  logic         reset;
  logic         r0_valid, r1_valid;
  logic         r0_ready, r1_ready;
  logic [1:0]   r0_op, r1_op;
  logic [W-1:0] r0_a, r0_b, r1_a, r1_b;
  logic         p0_valid, p1_valid;
  logic         p0_ready, p1_ready;
  logic [W-1:0] p_data;
  logic         p_cout;
  logic [1:0]   alu_op;
  logic [W-1:0] alu_i0, alu_i1, alu_o;
  logic         alu_cout;
  logic         busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // ALU behaviour: add, subtract (carry = no borrow), and, xor.
  function automatic logic [W:0] ref_alu(input logic [1:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    case (op)
      OP_0:    return {1'b0, a} + {1'b0, b};
      OP_1:    return {1'b0, a} + {1'b0, ~b} + 17'd1;
      OP_2:    return {1'b0, a & b};
      default: return {1'b0, a ^ b};
    endcase
  endfunction

  // The shared ALU sitting beside the scheduler.
  assign {alu_cout, alu_o} = ref_alu(alu_op, alu_i0, alu_i1);

  alu_share_arb #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_op(r0_op), .r0_a(r0_a), .r0_b(r0_b),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_op(r1_op), .r1_a(r1_a), .r1_b(r1_b),
    .p0_valid(p0_valid), .p0_ready(p0_ready), .p1_valid(p1_valid), .p1_ready(p1_ready),
    .p_data(p_data), .p_cout(p_cout),
    .alu_op(alu_op), .alu_i0(alu_i0), .alu_i1(alu_i1), .alu_o(alu_o), .alu_cout(alu_cout),
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Transaction-level reference: one job at a time, lone requester always
  // served, otherwise the client not served last goes first. Result appears
  // two cycles after acceptance and stays until its owner takes it.
  // ---------------------------------------------------------------------------
  int         cyc = 0;
  bit         outstanding = 0;
  int         last_served = 1;   // so client 0 is favoured out of reset
  int         acc_cyc = 0;
  int         t_id = 0;
  logic [1:0] t_op;
  logic [W-1:0] t_a, t_b;
  int         grant_q[$];
  int         resp_cnt[2] = '{0, 0};

  always @(negedge clk) begin
    bit exp_g;
    bit pv;
    int exp_id;
    cyc++;
    if (reset) begin
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_ready", 64'({r1_ready, r0_ready}), 64'd0);
      chk("rst_pvalid", 64'({p1_valid, p0_valid}), 64'd0);
      chk("rst_alu", 64'({alu_op, alu_i0, alu_i1}), 64'd0);
      chk("rst_result", 64'({p_cout, p_data}), 64'd0);
      outstanding = 0;
      last_served = 1;
    end else begin
      exp_g  = !outstanding && (r0_valid || r1_valid);
      exp_id = (r0_valid && r1_valid) ? 1 - last_served : (r1_valid ? 1 : 0);
      chk("grant", 64'({r1_ready, r0_ready}), exp_g ? (exp_id == 1 ? 64'd2 : 64'd1) : 64'd0);
      chk("busy", 64'(busy), 64'(outstanding));
      if (outstanding && cyc == acc_cyc + 1)
        chk("alu_in", 64'({alu_op, alu_i0, alu_i1}), 64'({t_op, t_a, t_b}));
      pv = outstanding && (cyc >= acc_cyc + 2);
      chk("pvalid", 64'({p1_valid, p0_valid}), pv ? (t_id == 1 ? 64'd2 : 64'd1) : 64'd0);
      if (pv) begin
        chk("result", 64'({p_cout, p_data}), 64'(ref_alu(t_op, t_a, t_b)));
        if (t_id == 1 ? p1_ready : p0_ready) begin
          outstanding = 0;
          last_served = t_id;
          resp_cnt[t_id]++;
        end
      end
      if (exp_g) begin
        outstanding = 1;
        t_id    = exp_id;
        t_op    = (exp_id == 1) ? r1_op : r0_op;
        t_a     = (exp_id == 1) ? r1_a  : r0_a;
        t_b     = (exp_id == 1) ? r1_b  : r0_b;
        acc_cyc = cyc;
        grant_q.push_back(exp_id);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Client drivers
  // ---------------------------------------------------------------------------
  task automatic start(input int c, input logic [1:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    if (c == 0) begin r0_valid = 1'b1; r0_op = op; r0_a = a; r0_b = b; end
    else        begin r1_valid = 1'b1; r1_op = op; r1_a = a; r1_b = b; end
  endtask

  // Returns at posedge+1 after the accepting edge, i.e. during EXEC.
  task automatic wait_acc(input int c);
    bit got = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      got = (c == 0) ? r0_ready : r1_ready;
    end
    if (!got) chk("accept_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    if (c == 0) r0_valid = 1'b0; else r1_valid = 1'b0;
  endtask

  task automatic req(input int c, input logic [1:0] op, input logic [W-1:0] a,
                     input logic [W-1:0] b);
    start(c, op, a, b);
    wait_acc(c);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk("idle_timeout", 64'(busy), 64'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base0, base1, gbase;
    bit sat_done;
    bit g0, g1;

    reset = 1'b1;
    r0_valid = 0; r1_valid = 0; r0_op = 0; r1_op = 0;
    r0_a = 0; r0_b = 0; r1_a = 0; r1_b = 0;
    p0_ready = 0; p1_ready = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Idle after reset: everything stays at zero.
    repeat (4) begin
      @(negedge clk);
      chk("idle_outputs", 64'({busy, r0_ready, r1_ready, p0_valid, p1_valid}), 64'd0);
      chk("idle_alu", 64'({alu_op, alu_i0, alu_i1}), 64'd0);
      chk("idle_result", 64'({p_cout, p_data}), 64'd0);
    end
    @(posedge clk); #1;

    // Lone client 0: ffff + 0001 wraps with carry out.
    p0_ready = 1'b1;
    req(0, OP_0, 16'hffff, 16'h0001);
    @(negedge clk);
    chk("c0_exec_ops", 64'({alu_op, alu_i0, alu_i1}), 64'({OP_0, 16'hffff, 16'h0001}));
    @(negedge clk);
    chk("c0_resp_valid", 64'({p1_valid, p0_valid}), 64'd1);
    chk("c0_resp_data", 64'({p_cout, p_data}), 64'h1_0000);
    wait_idle();

    // Fresh reset, both ask together: 0, 1, then 0 again.
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    p1_ready = 1'b1;
    gbase = grant_q.size();
    fork
      req(0, OP_1, 16'haa55, 16'h55aa);
      req(1, OP_1, 16'h0001, 16'h7fff);
    join
    fork
      req(0, OP_1, 16'h1111, 16'h2222);
      req(1, OP_1, 16'h3333, 16'h0003);
    join
    wait_idle();
    chk("rr_count", 64'(grant_q.size() - gbase), 64'd4);
    if (grant_q.size() - gbase == 4) begin
      chk("rr_first", 64'(grant_q[gbase]), 64'd0);
      chk("rr_second", 64'(grant_q[gbase + 1]), 64'd1);
      chk("rr_third", 64'(grant_q[gbase + 2]), 64'd0);
    end

    // Response held off for 5 cycles while client 1 waits.
    @(posedge clk); #1;
    p0_ready = 1'b0;
    req(0, OP_3, 16'h1234, 16'h00ff);
    start(1, OP_2, 16'hf0f0, 16'h3c3c);
    @(negedge clk);                     // EXEC
    repeat (5) begin
      @(negedge clk);
      chk("hold_resp", 64'({p0_valid, p_cout, p_data}), 64'({1'b1, 1'b0, 16'h12cb}));
      chk("hold_no_r1", 64'(r1_ready), 64'd0);
    end
    @(posedge clk); #1 p0_ready = 1'b1;
    wait_acc(1);
    wait_idle();

    // Reset during EXEC drops the job immediately.
    @(posedge clk); #1;
    base0 = resp_cnt[0];
    req(0, OP_0, 16'h0f0f, 16'h0101);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_alu", 64'({alu_op, alu_i0, alu_i1}), 64'd0);
    @(posedge clk); #1 reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("dropped_no_resp", 64'(resp_cnt[0] - base0), 64'd0);
    @(posedge clk); #1;
    base1 = resp_cnt[1];
    req(1, OP_0, 16'h8000, 16'h8000);
    wait_idle();
    chk("after_rst_resp", 64'(resp_cnt[1] - base1), 64'd1);

    // Both clients saturating, random ops/operands and response ready.
    @(posedge clk); #1;
    base0 = resp_cnt[0];
    base1 = resp_cnt[1];
    gbase = grant_q.size();
    sat_done = 0;
    fork
      begin
        repeat (N_SAT) req(0, 2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom));
      end
      begin
        repeat (N_SAT) req(1, 2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom));
      end
      begin
        while (!sat_done) begin
          @(posedge clk); #1;
          p0_ready = 1'($urandom_range(0, 1));
          p1_ready = 1'($urandom_range(0, 1));
          if (r0_valid == 0 && r1_valid == 0 && !busy) sat_done = 1;
        end
      end
    join
    p0_ready = 1'b1;
    p1_ready = 1'b1;
    wait_idle();
    chk("sat_resp0", 64'(resp_cnt[0] - base0), 64'(N_SAT));
    chk("sat_resp1", 64'(resp_cnt[1] - base1), 64'(N_SAT));
    for (int i = gbase + 1; i < grant_q.size(); i++)
      chk("sat_alternate", 64'(grant_q[i] != grant_q[i - 1]), 64'd1);

    // Random valid toggling, including withdrawals before grant.
    @(posedge clk); #1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      g0 = r0_ready;
      g1 = r1_ready;
      @(posedge clk); #1;
      if (!r0_valid || g0 || $urandom_range(0, 3) == 0) begin
        r0_valid = 1'($urandom_range(0, 1));
        r0_op = 2'($urandom_range(0, 3)); r0_a = 16'($urandom); r0_b = 16'($urandom);
      end
      if (!r1_valid || g1 || $urandom_range(0, 3) == 0) begin
        r1_valid = 1'($urandom_range(0, 1));
        r1_op = 2'($urandom_range(0, 3)); r1_a = 16'($urandom); r1_b = 16'($urandom);
      end
      p0_ready = 1'($urandom_range(0, 1));
      p1_ready = 1'($urandom_range(0, 1));
    end
    r0_valid = 0;
    r1_valid = 0;
    p0_ready = 1'b1;
    p1_ready = 1'b1;
    wait_idle();
    chk("final_idle", 64'({busy, p0_valid, p1_valid}), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
